// File: rtl/button_debouncer.sv
// -----------------------------------------------------------------------------
// button_debouncer
//
// Brings a raw, asynchronous, active-low push-button into the clk domain
// through a two-flop synchronizer. The debounced level changes only after the
// synchronized input has held a new level for DEBOUNCE_CYCLES consecutive
// cycles. Any opposite sample during that time restarts qualification.
// Both outputs are registered (Moore), so there is no combinational path from
// rawButton to either output.
//
// Ports:
//   clk        in   system clock; all state changes on the rising edge
//   rst        in   asynchronous, active-high reset
//   rawButton  in   raw button pin, active-low, asynchronous, may bounce
//   outButton  out  debounced active-low level (1 = released, 0 = pressed)
//   busy       out  high while a candidate transition is being qualified
// -----------------------------------------------------------------------------
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_WIDTH       = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic rawButton,
    output logic outButton,
    output logic busy
);

    typedef enum logic [1:0] {
        RELEASED        = 2'b00,
        CONFIRM_PRESS   = 2'b01,
        PRESSED         = 2'b10,
        CONFIRM_RELEASE = 2'b11
    } state_t;

    // Terminal count: the input must hold for this many increments beyond the
    // cycle that entered the confirm state.
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic                 sync1_q, sync1_d;
    logic                 sync2_q, sync2_d;
    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 out_q, out_d;
    logic                 busy_q, busy_d;

    // Synchronizer: straight flop-to-flop, nothing in between.
    always_comb begin
        sync1_d = rawButton;
        sync2_d = sync1_q;
    end

    // State register (includes synchronizer, counter and registered outputs).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= RELEASED;
            cnt_q   <= '0;
            out_q   <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state logic. The counter is cleared on every state change so each
    // qualification starts from zero and can never exceed CNT_LAST.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RELEASED: begin
                cnt_d = '0;
                if (!sync2_q) begin
                    state_d = CONFIRM_PRESS;
                end
            end
            CONFIRM_PRESS: begin
                if (sync2_q) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            PRESSED: begin
                cnt_d = '0;
                if (sync2_q) begin
                    state_d = CONFIRM_RELEASE;
                end
            end
            CONFIRM_RELEASE: begin
                if (!sync2_q) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            default: begin
                state_d = RELEASED;
                cnt_d   = '0;
            end
        endcase
    end

    // Output logic, decoded from the next state so the registered outputs
    // change on the same edge as the state they describe.
    always_comb begin
        out_d  = 1'b1;
        busy_d = 1'b0;
        case (state_d)
            RELEASED:        begin out_d = 1'b1; busy_d = 1'b0; end
            CONFIRM_PRESS:   begin out_d = 1'b1; busy_d = 1'b1; end
            PRESSED:         begin out_d = 1'b0; busy_d = 1'b0; end
            CONFIRM_RELEASE: begin out_d = 1'b0; busy_d = 1'b1; end
            default:         begin out_d = 1'b1; busy_d = 1'b0; end
        endcase
    end

    assign outButton = out_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_button_debouncer.sv
// -----------------------------------------------------------------------------
// tb_button_debouncer
//
// Drives button_debouncer (DEBOUNCE_CYCLES=4, CNT_WIDTH=3) with directed
// scenarios followed by randomized bouncing input and random resets. A
// behavioural model tracks the expected debounced level: the output flips once
// DEBOUNCE_CYCLES+1 consecutive synchronized samples disagree with it, and
// busy is high while such a run is in progress.
// -----------------------------------------------------------------------------
module tb_button_debouncer;

    localparam int DC = 4;
    localparam int CW = 3;

    logic clk       = 1'b0;
    logic rst       = 1'b1;
    logic rawButton = 1'b1;
    logic outButton;
    logic busy;

    int n_checks = 0;
    int n_fail   = 0;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DC),
        .CNT_WIDTH      (CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rawButton(rawButton),
        .outButton(outButton),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Behavioural model: two-sample delay line for the synchronizer, then the
    // length of the current run of samples that disagree with the output.
    logic m_s1  = 1'b1;
    logic m_s2  = 1'b1;
    logic m_out = 1'b1;
    int   m_run = 0;
    logic m_busy;

    assign m_busy = (m_run != 0);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_s1  <= 1'b1;
            m_s2  <= 1'b1;
            m_out <= 1'b1;
            m_run <= 0;
        end else begin
            m_s1 <= rawButton;
            m_s2 <= m_s1;
            if (m_s2 != m_out) begin
                if (m_run + 1 == DC + 1) begin
                    m_out <= ~m_out;
                    m_run <= 0;
                end else begin
                    m_run <= m_run + 1;
                end
            end else begin
                m_run <= 0;
            end
        end
    end

    task automatic chk(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            chk("model_out", outButton, m_out);
            chk("model_busy", busy, m_busy);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    logic       lvl;
    int         len;
    logic [5:0] bnc;
    logic       prev, cur, v;
    int         falls, rises;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_out", outButton, 1'b1);
        chk("reset_busy", busy, 1'b0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_out", outButton, 1'b1);

        // Clean press: E1 is the first posedge after the change
        @(negedge clk);
        rawButton = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk("press_e2_busy", busy, 1'b0);
        @(posedge clk);
        #1 chk("press_e3_busy", busy, 1'b1);
        chk("press_e3_out", outButton, 1'b1);
        repeat (3) @(posedge clk);
        #1 chk("press_e6_out", outButton, 1'b1);
        chk("press_e6_busy", busy, 1'b1);
        @(posedge clk);
        #1 chk("press_e7_out", outButton, 1'b0);
        chk("press_e7_busy", busy, 1'b0);
        chk("model_pin_press", m_out, 1'b0);
        repeat (10) @(posedge clk);
        #1 chk("press_hold_out", outButton, 1'b0);

        // Three-cycle release glitch while pressed is rejected
        @(negedge clk) rawButton = 1'b1;
        @(negedge clk) rawButton = 1'b1;
        @(negedge clk) rawButton = 1'b1;
        @(negedge clk) rawButton = 1'b0;
        repeat (12) @(posedge clk);
        #1 chk("glitch_out", outButton, 1'b0);
        chk("glitch_busy", busy, 1'b0);

        // Clean release
        @(negedge clk) rawButton = 1'b1;
        repeat (6) @(posedge clk);
        #1 chk("release_e6_out", outButton, 1'b0);
        chk("release_e6_busy", busy, 1'b1);
        @(posedge clk);
        #1 chk("release_e7_out", outButton, 1'b1);
        chk("release_e7_busy", busy, 1'b0);
        chk("model_pin_release", m_out, 1'b1);
        repeat (5) @(posedge clk);

        // Bounce 0,0,1,0,0,1 then hold 0
        bnc = 6'b100100;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk) rawButton = bnc[i];
        end
        @(negedge clk);
        chk("bounce_out", outButton, 1'b1);
        rawButton = 1'b0;
        @(posedge clk);
        repeat (5) @(posedge clk);
        #1 chk("bounce_e6_out", outButton, 1'b1);
        @(posedge clk);
        #1 chk("bounce_e7_out", outButton, 1'b0);
        repeat (3) @(posedge clk);

        // Reset while pressed, button still held through deassertion
        @(negedge clk);
        #2 rst = 1'b1;
        #1 chk("rst_pressed_out", outButton, 1'b1);
        chk("rst_pressed_busy", busy, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1 chk("rst_held_e6_out", outButton, 1'b1);
        @(posedge clk);
        #1 chk("rst_held_e7_out", outButton, 1'b0);

        // Reset mid-qualification (CONFIRM_PRESS, counter=2)
        @(negedge clk) rawButton = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk) rawButton = 1'b0;
        repeat (5) @(posedge clk);
        #1 chk("confirm_busy", busy, 1'b1);
        #1 rst = 1'b1;
        #1 chk("rst_confirm_out", outButton, 1'b1);
        chk("rst_confirm_busy", busy, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1 chk("rst_conf_e6_out", outButton, 1'b1);
        @(posedge clk);
        #1 chk("rst_conf_e7_out", outButton, 1'b0);

        // Integration-style: bouncy 20-cycle press then bouncy release must
        // yield exactly one falling and one rising edge of the debounced level
        @(negedge clk) rawButton = 1'b1;
        repeat (10) @(posedge clk);
        falls = 0;
        rises = 0;
        @(negedge clk);
        prev = outButton;
        for (int i = 0; i < 38; i++) begin
            if (i < 20) v = (i == 1 || i == 4);
            else        v = (i != 21);
            rawButton = v;
            @(negedge clk);
            cur = outButton;
            if (prev && !cur) falls++;
            if (!prev && cur) rises++;
            prev = cur;
        end
        n_checks++;
        if (falls != 1) begin
            n_fail++;
            $display("FAIL integ_falls: got %0d, expected 1", falls);
        end
        n_checks++;
        if (rises != 1) begin
            n_fail++;
            $display("FAIL integ_rises: got %0d, expected 1", rises);
        end

        // Randomized bursts of bounce and stable levels, with random resets
        for (int b = 0; b < 400; b++) begin
            if ($urandom_range(0, 39) == 0) begin
                @(negedge clk);
                #2 rst = 1'b1;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                #2 rst = 1'b0;
            end
            lvl = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 14);
            repeat (len) begin
                @(negedge clk);
                rawButton = lvl;
            end
        end
        repeat (12) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
